// File: rtl/pcie_rx_pkg.sv
// rtl/pcie_rx_pkg.sv - shared constants, state enum and helpers for the rx symbol aligner
package pcie_rx_pkg;

  localparam int SYM_W = 10;
  localparam int OFF_W = 4;
  localparam int CNT_W = 3;

  // K28.5 in both running disparities, bit0 = 'a'
  localparam logic [SYM_W-1:0] COM_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] COM_RDP = 10'h283;

  typedef enum logic [1:0] {
    ST_UNALIGNED = 2'd0,
    ST_ACQUIRE   = 2'd1,
    ST_LOCKED    = 2'd2
  } align_state_e;

  typedef logic [OFF_W-1:0] offset_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pcie_rx_symbol_align_if.sv
// rtl/pcie_rx_symbol_align_if.sv - raw word in / aligned symbol out bundle of the aligner
interface pcie_rx_symbol_align_if;

  logic                                  RXELECIDLE;
  logic [pcie_rx_pkg::SYM_W-1:0]         HSS_RXD;
  logic [pcie_rx_pkg::SYM_W-1:0]         RXD_ALIGNED;
  logic                                  RXD_VALID;
  logic                                  SYMBOL_LOCK;
  logic                                  COM_DET;
  logic [pcie_rx_pkg::OFF_W-1:0]         ALIGN_OFFSET;

  modport master (
    output RXELECIDLE, HSS_RXD,
    input  RXD_ALIGNED, RXD_VALID, SYMBOL_LOCK, COM_DET, ALIGN_OFFSET
  );

  modport slave (
    input  RXELECIDLE, HSS_RXD,
    output RXD_ALIGNED, RXD_VALID, SYMBOL_LOCK, COM_DET, ALIGN_OFFSET
  );

endinterface

// File: rtl/pcie_com_detect.sv
// rtl/pcie_com_detect.sv - combinational K28.5 match at each of the ten slice offsets
module pcie_com_detect
  import pcie_rx_pkg::*;
(
  input  logic [2*SYM_W-1:0] window_i,
  output logic [SYM_W-1:0]   match_o
);

  // The top bit can never start a full symbol; it only completes offset 9's neighbour.
  logic unused_top;
  assign unused_top = window_i[2*SYM_W-1];

  always_comb begin
    match_o = '0;
    for (int k = 0; k < SYM_W; k++) begin
      match_o[k] = (window_i[k +: SYM_W] == COM_RDN) || (window_i[k +: SYM_W] == COM_RDP);
    end
  end

endmodule

// File: rtl/pcie_rx_symbol_align.sv
// rtl/pcie_rx_symbol_align.sv - comma-based 10b symbol aligner with lock/loss hysteresis
module pcie_rx_symbol_align
  import pcie_rx_pkg::*;
#(
  parameter int LOCK_COMS = 2,
  parameter int LOSS_COMS = 4
) (
  input  logic                  PCLK250,
  input  logic                  CNTL_RESETN_P0,
  pcie_rx_symbol_align_if.slave rx
);

  logic [SYM_W-1:0]   r0_q;
  align_state_e       state_q, state_d;
  offset_t            offset_q, offset_d;
  logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [SYM_W-1:0]   aligned_q, aligned_d;
  logic               valid_q, valid_d;
  logic               lock_q, lock_d;
  logic               com_det_q, com_det_d;

  logic [2*SYM_W-1:0] window;
  logic [SYM_W-1:0]   match;
  logic [SYM_W-1:0]   slice;
  logic               any_com;
  logic               com_held;
  offset_t            low_k;

  assign window = {rx.HSS_RXD, r0_q};

  pcie_com_detect u_com_detect (
    .window_i (window),
    .match_o  (match)
  );

  always_comb begin
    low_k = '0;
    for (int k = SYM_W - 1; k >= 0; k--) begin
      if (match[k]) low_k = offset_t'(k);
    end
  end

  assign any_com  = |match;
  assign com_held = match[offset_q];

  // A COM at the held offset always wins over COMs seen elsewhere in the window.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    com_cnt_d  = com_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rx.RXELECIDLE) begin
      state_d    = ST_UNALIGNED;
      com_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      case (state_q)
        ST_UNALIGNED: begin
          if (any_com) begin
            offset_d   = low_k;
            com_cnt_d  = CNT_W'(1);
            miss_cnt_d = '0;
            state_d    = (LOCK_COMS <= 1) ? ST_LOCKED : ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (com_held) begin
            com_cnt_d = sat_inc(com_cnt_q);
            if (com_cnt_d >= CNT_W'(LOCK_COMS)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else if (any_com) begin
            offset_d  = low_k;
            com_cnt_d = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (com_held) begin
            miss_cnt_d = '0;
          end else if (any_com) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            if (miss_cnt_d >= CNT_W'(LOSS_COMS)) begin
              state_d    = ST_UNALIGNED;
              com_cnt_d  = '0;
              miss_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_UNALIGNED;
      endcase
    end
  end

  // Slice with the offset being adopted this edge so the triggering COM comes out aligned.
  always_comb begin
    slice = '0;
    for (int k = 0; k < SYM_W; k++) begin
      if (offset_d == offset_t'(k)) slice = window[k +: SYM_W];
    end
  end

  assign valid_d   = (state_d != ST_UNALIGNED);
  assign lock_d    = (state_d == ST_LOCKED);
  assign aligned_d = valid_d ? slice : '0;
  assign com_det_d = valid_d & match[offset_d];

  always_ff @(posedge PCLK250 or negedge CNTL_RESETN_P0) begin
    if (!CNTL_RESETN_P0) begin
      r0_q       <= '0;
      state_q    <= ST_UNALIGNED;
      offset_q   <= '0;
      com_cnt_q  <= '0;
      miss_cnt_q <= '0;
      aligned_q  <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      com_det_q  <= 1'b0;
    end else begin
      r0_q       <= rx.HSS_RXD;
      state_q    <= state_d;
      offset_q   <= offset_d;
      com_cnt_q  <= com_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      aligned_q  <= aligned_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      com_det_q  <= com_det_d;
    end
  end

  assign rx.RXD_ALIGNED  = aligned_q;
  assign rx.RXD_VALID    = valid_q;
  assign rx.SYMBOL_LOCK  = lock_q;
  assign rx.COM_DET      = com_det_q;
  assign rx.ALIGN_OFFSET = offset_q;

endmodule

// File: tb/tb_pcie_rx_symbol_align.sv
// tb/tb_pcie_rx_symbol_align.sv - bit-stream driven bench with reference aligner model
module tb_pcie_rx_symbol_align;
  import pcie_rx_pkg::*;

  localparam int LOCK = 2;
  localparam int LOSS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pcie_rx_symbol_align_if rx_if ();

  pcie_rx_symbol_align #(.LOCK_COMS(LOCK), .LOSS_COMS(LOSS)) dut (
    .PCLK250        (clk),
    .CNTL_RESETN_P0 (rst_n),
    .rx             (rx_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit bq[$];
  longint pos = 0;
  bit last_bit = 1'b0;

  int m_st, m_off, m_cc, m_mc;
  logic [9:0] m_prev;
  logic [9:0] e_al;
  int e_valid, e_lock, e_det, e_off;

  int det_cnt, lock_det_at, cyc, last_det_cyc;
  bit prev_lock, gap_chk, src_track;
  logic [9:0] src_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_off = 0; m_cc = 0; m_mc = 0; m_prev = '0;
  endtask

  // Stream-level view: which of the ten bit positions in the last 20 received bits start a COM.
  task automatic model_step(input logic [9:0] w, input bit eidle);
    logic [19:0] win;
    logic [9:0]  hits;
    int first;
    win = {w, m_prev};
    m_prev = w;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      hits[k] = (win[k +: 10] == COM_RDN) || (win[k +: 10] == COM_RDP);
      if (hits[k] && first < 0) first = k;
    end
    if (eidle) begin
      m_st = 0; m_cc = 0; m_mc = 0;
    end else if (m_st == 0) begin
      if (first >= 0) begin
        m_off = first; m_cc = 1; m_mc = 0;
        m_st = (LOCK <= 1) ? 2 : 1;
      end
    end else if (m_st == 1) begin
      if (hits[m_off]) begin
        m_cc = (m_cc < 7) ? m_cc + 1 : 7;
        if (m_cc >= LOCK) begin m_st = 2; m_mc = 0; end
      end else if (first >= 0) begin
        m_off = first; m_cc = 1;
      end
    end else begin
      if (hits[m_off]) m_mc = 0;
      else if (first >= 0) begin
        m_mc = (m_mc < 7) ? m_mc + 1 : 7;
        if (m_mc >= LOSS) begin m_st = 0; m_cc = 0; m_mc = 0; end
      end
    end
    e_valid = (m_st != 0) ? 1 : 0;
    e_lock  = (m_st == 2) ? 1 : 0;
    e_off   = m_off;
    e_al    = e_valid ? win[m_off +: 10] : 10'h000;
    e_det   = (e_valid && hits[m_off]) ? 1 : 0;
  endtask

  task automatic push_bit(input bit b);
    bq.push_back(b);
    pos++;
    last_bit = b;
  endtask

  task automatic push_fill(input int n);
    repeat (n) push_bit(~last_bit);
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) push_bit(s[i]);
  endtask

  task automatic push_com_at(input int o, input bit rdp);
    while ((pos % 10) != o) push_fill(1);
    push_sym(rdp ? COM_RDP : COM_RDN);
    push_fill(30);
  endtask

  task automatic track_reset();
    det_cnt = 0; lock_det_at = -1; last_det_cyc = -1;
    prev_lock = rx_if.SYMBOL_LOCK;
  endtask

  // Entered and left at a falling edge; one rising edge per call.
  task automatic step(input bit eidle);
    logic [9:0] w;
    while (bq.size() < 10) push_fill(1);
    for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
    rx_if.HSS_RXD = w;
    rx_if.RXELECIDLE = eidle;
    @(posedge clk);
    #1;
    cyc++;
    model_step(w, eidle);
    check_eq("rxd_aligned", rx_if.RXD_ALIGNED, e_al);
    check_eq("rxd_valid", rx_if.RXD_VALID, e_valid);
    check_eq("symbol_lock", rx_if.SYMBOL_LOCK, e_lock);
    check_eq("com_det", rx_if.COM_DET, e_det);
    check_eq("align_offset", rx_if.ALIGN_OFFSET, e_off);
    if (rx_if.COM_DET) begin
      det_cnt++;
      if (gap_chk && last_det_cyc >= 0) check_eq("com_det_gap", cyc - last_det_cyc, 4);
      last_det_cyc = cyc;
    end
    if (!prev_lock && rx_if.SYMBOL_LOCK && lock_det_at < 0) lock_det_at = det_cnt;
    prev_lock = rx_if.SYMBOL_LOCK;
    if (src_track && rx_if.RXD_VALID && src_q.size() > 0)
      check_eq("src_symbol", rx_if.RXD_ALIGNED, src_q.pop_front());
    @(negedge clk);
  endtask

  task automatic drain();
    while (bq.size() > 0) step(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_aligned"}, rx_if.RXD_ALIGNED, 0);
    check_eq({tag, "_valid"}, rx_if.RXD_VALID, 0);
    check_eq({tag, "_lock"}, rx_if.SYMBOL_LOCK, 0);
    check_eq({tag, "_det"}, rx_if.COM_DET, 0);
    check_eq({tag, "_offset"}, rx_if.ALIGN_OFFSET, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [9:0] s;
    rx_if.HSS_RXD = '0;
    rx_if.RXELECIDLE = 1'b0;
    cyc = 0; gap_chk = 0; src_track = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_fill(40);
    drain();

    // Offset 0: eight COMs, four words apart
    track_reset();
    gap_chk = 1;
    for (int j = 0; j < 8; j++) push_com_at(0, (j % 2) == 1);
    drain();
    gap_chk = 0;
    check_eq("off0_lock", rx_if.SYMBOL_LOCK, 1);
    check_eq("off0_offset", rx_if.ALIGN_OFFSET, 0);
    check_eq("off0_lock_after", lock_det_at, 2);
    check_eq("off0_det_count", det_cnt, 8);

    // Shifted by 3 bits: aligned output reproduces the source symbols
    step(1'b1);
    check_eq("eidle_valid", rx_if.RXD_VALID, 0);
    check_eq("eidle_aligned", rx_if.RXD_ALIGNED, 0);
    track_reset();
    while ((pos % 10) != 3) push_fill(1);
    for (int j = 0; j < 3; j++) begin
      s = (j % 2) ? COM_RDP : COM_RDN;
      push_sym(s); src_q.push_back(s);
      for (int d = 0; d < 3; d++) begin
        s = $urandom_range(0, 1) ? 10'h2AA : 10'h155;
        push_sym(s); src_q.push_back(s);
      end
    end
    push_fill(30);
    src_track = 1;
    drain();
    src_track = 0;
    check_eq("shift3_src_consumed", src_q.size(), 0);
    check_eq("shift3_offset", rx_if.ALIGN_OFFSET, 3);
    check_eq("shift3_lock", rx_if.SYMBOL_LOCK, 1);
    check_eq("shift3_lock_after", lock_det_at, 2);

    // Foreign COMs: three then a home COM keeps lock; four in a row drop it
    for (int j = 0; j < 3; j++) push_com_at(7, j[0]);
    push_com_at(3, 1'b0);
    drain();
    check_eq("foreign3_lock", rx_if.SYMBOL_LOCK, 1);
    for (int j = 0; j < 3; j++) push_com_at(7, j[0]);
    drain();
    check_eq("foreign_cleared_lock", rx_if.SYMBOL_LOCK, 1);
    check_eq("foreign_cleared_offset", rx_if.ALIGN_OFFSET, 3);
    push_com_at(7, 1'b1);
    drain();
    check_eq("foreign4_lock", rx_if.SYMBOL_LOCK, 0);
    check_eq("foreign4_valid", rx_if.RXD_VALID, 0);

    // Re-acquire at a new offset while still in ACQUIRE
    push_com_at(2, 1'b0);
    drain();
    check_eq("acq2_offset", rx_if.ALIGN_OFFSET, 2);
    check_eq("acq2_valid", rx_if.RXD_VALID, 1);
    push_com_at(5, 1'b1);
    drain();
    check_eq("acq5_offset", rx_if.ALIGN_OFFSET, 5);
    check_eq("acq5_lock", rx_if.SYMBOL_LOCK, 0);
    check_eq("acq5_valid", rx_if.RXD_VALID, 1);
    push_com_at(5, 1'b0);
    drain();
    check_eq("acq5_locked", rx_if.SYMBOL_LOCK, 1);

    // Electrical idle pulse while locked
    step(1'b1);
    check_eq("idle_lock", rx_if.SYMBOL_LOCK, 0);
    check_eq("idle_valid", rx_if.RXD_VALID, 0);
    check_eq("idle_aligned", rx_if.RXD_ALIGNED, 0);

    // Reset mid-lock, then relock needs two fresh COMs
    push_com_at(1, 1'b0);
    push_com_at(1, 1'b1);
    drain();
    check_eq("prereset_lock", rx_if.SYMBOL_LOCK, 1);
    do_reset();
    track_reset();
    for (int j = 0; j < 3; j++) push_com_at(6, j[0]);
    drain();
    check_eq("relock_after", lock_det_at, 2);
    check_eq("relock_offset", rx_if.ALIGN_OFFSET, 6);

    // Random soak: random words, COMs and bit slips, rare electrical idle
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) push_sym($urandom_range(0, 1) ? COM_RDP : COM_RDN);
      else if (r == 3) push_fill($urandom_range(1, 9));
      else begin
        s = 10'($urandom);
        push_sym(s);
      end
      while (bq.size() >= 10) step($urandom_range(0, 63) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_rx_symbol_align.md
PCIE_RX_SYMBOL_ALIGN -- requirements
Module: pcie_rx_symbol_align

Interface
REQ-001 Parameter LOCK_COMS, default 2: number of COMs at one offset needed to declare lock (range 1..7).
REQ-002 Parameter LOSS_COMS, default 4: consecutive COMs at a foreign offset that drop lock (range 1..7).
REQ-003 PCLK250  input  1  symbol clock; all state on rising edge.
REQ-004 CNTL_RESETN_P0  input  1  asynchronous, active-low reset.
REQ-005 RXELECIDLE  input  1  receiver electrical idle; forces loss of alignment.
REQ-006 HSS_RXD  input  10  raw deserialized word, arbitrary bit offset; bit0 earliest received.
REQ-007 RXD_ALIGNED  output  10  aligned 10b symbol for the 8b/10b decoder; bit0 = 'a'.
REQ-008 RXD_VALID  output  1  RXD_ALIGNED holds a symbol sliced at a known offset.
REQ-009 SYMBOL_LOCK  output  1  high in state LOCKED only.
REQ-010 COM_DET  output  1  one-cycle pulse coincident with a COM on RXD_ALIGNED.
REQ-011 ALIGN_OFFSET  output  4  current slice offset, 0..9.

Function
REQ-012 A register r0 SHALL hold the previous HSS_RXD; window = {HSS_RXD, r0} (20 bits); candidate k = window[k+9:k], k = 0..9.
REQ-013 COM SHALL match K28.5 in either disparity: 10'h17C (RD-) or 10'h283 (RD+).
REQ-014 States: UNALIGNED, ACQUIRE, LOCKED; reset state UNALIGNED.
REQ-015 UNALIGNED: on any COM match, take lowest matching k as offset, com_cnt=1, go ACQUIRE (or LOCKED if LOCK_COMS=1); otherwise stay.
REQ-016 ACQUIRE: COM at held offset -> com_cnt+1; reaching LOCK_COMS -> LOCKED; COM only at another offset -> new offset (lowest), com_cnt=1; no COM -> hold.
REQ-017 LOCKED: COM at held offset clears miss_cnt; COM only at foreign offsets -> miss_cnt+1; miss_cnt reaching LOSS_COMS -> UNALIGNED, RXD_VALID low next cycle.
REQ-018 COM at held offset SHALL take priority over simultaneous foreign-offset COMs in every state.
REQ-019 Outputs SHALL be registered: RXD_ALIGNED updated on edge n+1 for a word present on HSS_RXD at edge n (offset 0); latency 1 edge after r0 capture.
REQ-020 On an offset change, the slice for that edge SHALL use the new offset, so the triggering COM itself appears aligned with COM_DET=1.
REQ-021 RXD_VALID SHALL be 1 in ACQUIRE and LOCKED, 0 in UNALIGNED; RXD_ALIGNED = 10'h000 while RXD_VALID=0.
REQ-022 COM_DET SHALL pulse only for COMs at the offset used for the slice.
REQ-023 RXELECIDLE=1 SHALL force UNALIGNED on the next edge, clearing com_cnt and miss_cnt, regardless of state or simultaneous COMs.
REQ-024 com_cnt and miss_cnt SHALL be 3-bit and saturate; no wrap-around.

Reset
REQ-025 Reset asserted: state UNALIGNED, r0=0, offset=0, counters 0, RXD_ALIGNED=0, RXD_VALID=0, SYMBOL_LOCK=0, COM_DET=0, ALIGN_OFFSET=0.
REQ-026 Reset mid-lock SHALL clear all state immediately; realignment after release requires LOCK_COMS fresh COMs.

Structure
REQ-027 Package pcie_rx_pkg SHALL hold COM_RDN=10'h17C, COM_RDP=10'h283, the state enum, and offset width.
REQ-028 Sub-module pcie_com_detect SHALL be combinational: 20-bit window in, 10-bit per-offset match vector out.
REQ-029 Offset selection (lowest-k priority encoder) and 10:1 slice mux SHALL live in the top module.

Verification
REQ-030 Offset-0 stream: 8 COMs (RD-/RD+ alternating) each 4 words apart -> LOCKED after 2nd COM, ALIGN_OFFSET=0, COM_DET every 4th cycle.
REQ-031 Stream shifted by 3 bits -> ALIGN_OFFSET=3, RXD_ALIGNED sequence equals unshifted source symbols, SYMBOL_LOCK after 2 COMs.
REQ-032 Locked at 3, then 4 COMs at offset 7 -> SYMBOL_LOCK drops on the 4th; 3 foreign COMs then one at 3 -> lock retained, miss_cnt=0.
REQ-033 ACQUIRE at offset 2, next COM at offset 5 -> ALIGN_OFFSET=5, state remains ACQUIRE, lock after one more COM at 5.
REQ-034 RXELECIDLE pulsed 1 cycle while LOCKED -> next edge UNALIGNED, RXD_VALID=0, RXD_ALIGNED=0.
REQ-035 Reset asserted mid-lock -> all outputs 0 asynchronously; after release, lock again after exactly 2 COMs.
